// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and iteration-count helpers for the divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
  function automatic int div_iters(input int n_width, input int step_bits);
    return n_width / step_bits;
  endfunction
  localparam int DIV_ITERS = div_iters(32, 1);
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division bit, shifting in a dividend bit and trial-subtracting the divisor
module div_step #(
  parameter int N_WIDTH = 32
) (
  input  logic [N_WIDTH-1:0] rem_i,
  input  logic               bit_i,
  input  logic [N_WIDTH-1:0] divisor_i,
  output logic [N_WIDTH-1:0] rem_o,
  output logic               q_o
);
  logic [N_WIDTH:0] shf, diff;
  assign shf   = {rem_i, bit_i};
  assign diff  = shf - {1'b0, divisor_i};
  // Partial remainder stays below the divisor, so a borrow shows up in the top bit of the N+1-bit difference.
  assign q_o   = ~diff[N_WIDTH];
  assign rem_o = q_o ? diff[N_WIDTH-1:0] : shf[N_WIDTH-1:0];
endmodule

// File: rtl/divn.sv
// divn: iterative restoring divider, signed/unsigned, STEP_BITS quotient bits per cycle
module divn
  import div_pkg::*;
#(
  parameter int N_WIDTH   = 32,
  parameter int STEP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_divsigned,
  input  logic               i_divstart,
  input  logic [N_WIDTH-1:0] i_dividend,
  input  logic [N_WIDTH-1:0] i_divisor,
  input  logic               i_annul,
  input  logic               i_res_rdy,
  output logic               o_ready,
  output logic               o_done_vld,
  output logic [N_WIDTH-1:0] o_quotient,
  output logic [N_WIDTH-1:0] o_remainder,
  output logic               o_div_zero
);
  localparam int ITERS = div_iters(N_WIDTH, STEP_BITS);
  localparam int CW    = $clog2(ITERS + 1);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [N_WIDTH-1:0] rem_q, quo_q, dvs_q, quot_q, remo_q;
  logic               sign_a_q, sign_b_q, sgn_q, dz_q;
  logic [N_WIDTH-1:0] rem_d, quo_d;
  logic [N_WIDTH-1:0] rem_c [STEP_BITS+1];
  logic [STEP_BITS-1:0] qbits;

  function automatic logic [N_WIDTH-1:0] mag(input logic [N_WIDTH-1:0] v, input logic s);
    return (s && v[N_WIDTH-1]) ? -v : v;
  endfunction

  // quo_q starts as the dividend magnitude and is shifted out MSB first while quotient bits shift in
  assign rem_c[0] = rem_q;
  for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
    div_step #(.N_WIDTH(N_WIDTH)) u_step (
      .rem_i     (rem_c[g]),
      .bit_i     (quo_q[N_WIDTH-1-g]),
      .divisor_i (dvs_q),
      .rem_o     (rem_c[g+1]),
      .q_o       (qbits[STEP_BITS-1-g])
    );
  end
  assign rem_d = rem_c[STEP_BITS];
  assign quo_d = {quo_q[N_WIDTH-STEP_BITS-1:0], qbits};

  assign o_ready     = state_q == IDLE;
  assign o_done_vld  = state_q == DONE;
  assign o_quotient  = quot_q;
  assign o_remainder = remo_q;
  assign o_div_zero  = dz_q;

  // Control FSM plus datapath and result registers; annul wins over every other transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      remo_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sgn_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_divstart && !i_annul) begin
          if (i_divisor == '0) begin
            quot_q  <= '1;
            remo_q  <= i_dividend;
            dz_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            rem_q    <= '0;
            quo_q    <= mag(i_dividend, i_divsigned);
            dvs_q    <= mag(i_divisor, i_divsigned);
            sign_a_q <= i_divsigned & i_dividend[N_WIDTH-1];
            sign_b_q <= i_divsigned & i_divisor[N_WIDTH-1];
            sgn_q    <= i_divsigned;
            dz_q     <= 1'b0;
            cnt_q    <= CW'(ITERS);
            state_q  <= CALC;
          end
        end
        CALC: if (i_annul) state_q <= IDLE;
        else begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: if (i_annul) state_q <= IDLE;
        else begin
          quot_q  <= (sgn_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
          remo_q  <= (sgn_q && sign_a_q) ? -rem_q : rem_q;
          state_q <= DONE;
        end
        DONE: if (i_annul || i_res_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divn.sv
// tb_divn: directed self-checking bench for divn (STEP_BITS 1 and 2 instances share stimulus)
module tb_divn;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dsigned = 1'b0, dstart = 1'b0, annul = 1'b0, res_rdy = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic        rdy1, vld1, dz1, rdy2, vld2, dz2;
  logic [31:0] q1, r1, q2, r2;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  divn #(.N_WIDTH(32), .STEP_BITS(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_divsigned(dsigned), .i_divstart(dstart),
    .i_dividend(dividend), .i_divisor(divisor), .i_annul(annul), .i_res_rdy(res_rdy),
    .o_ready(rdy1), .o_done_vld(vld1), .o_quotient(q1), .o_remainder(r1), .o_div_zero(dz1));

  divn #(.N_WIDTH(32), .STEP_BITS(2)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_divsigned(dsigned), .i_divstart(dstart),
    .i_dividend(dividend), .i_divisor(divisor), .i_annul(annul), .i_res_rdy(res_rdy),
    .o_ready(rdy2), .o_done_vld(vld2), .o_quotient(q2), .o_remainder(r2), .o_div_zero(dz2));

  task automatic start(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dsigned = s; dividend = a; divisor = b; dstart = 1'b1;
    @(negedge clk);
    dstart = 1'b0;
  endtask

  task automatic wait_vld1(output int cyc);
    cyc = 0;
    while (!vld1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic take();
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({rdy1, vld1, q1, r1, dz1} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_u1: got rdy=%b vld=%b q=%h r=%h dz=%b, need 1 0 0 0 0", rdy1, vld1, q1, r1, dz1);
    end
    n_tests++;
    if ({rdy2, vld2, q2, r2, dz2} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_u2: got rdy=%b vld=%b q=%h r=%h dz=%b, need 1 0 0 0 0", rdy2, vld2, q2, r2, dz2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int cyc;
    start(1'b0, 32'd100, 32'd7);
    wait_vld1(cyc);
    n_tests++;
    if ({q1, r1, dz1} !== {32'd14, 32'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL u_100_7: got q=%0d r=%0d dz=%b, need q=14 r=2 dz=0", q1, r1, dz1);
    end
    n_tests++;
    if (cyc != 33) begin
      n_fail++;
      $display("FAIL u_latency: got %0d cycles, need 33", cyc);
    end
    take();
    n_tests++;
    if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL u_release: got rdy=%b vld=%b, need 1 0", rdy1, vld1);
    end
  endtask

  task automatic test_signed();
    int cyc;
    logic [31:0] vec [3][4] = '{
      '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE},
      '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2},
      '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0}};
    for (int i = 0; i < 3; i++) begin
      start(1'b1, vec[i][0], vec[i][1]);
      wait_vld1(cyc);
      n_tests++;
      if ({q1, r1, dz1, vld1} !== {vec[i][2], vec[i][3], 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL signed_%0d: got q=%h r=%h dz=%b vld=%b, need q=%h r=%h dz=0 vld=1",
                 i, q1, r1, dz1, vld1, vec[i][2], vec[i][3]);
      end
      take();
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    for (int m = 0; m < 2; m++) begin
      start(m[0], 32'd5, 32'd0);
      wait_vld1(cyc);
      n_tests++;
      if ({q1, r1, dz1} !== {32'hFFFFFFFF, 32'd5, 1'b1} || cyc != 0) begin
        n_fail++;
        $display("FAIL dz_mode%0d: got q=%h r=%h dz=%b wait=%0d, need q=ffffffff r=5 dz=1 wait=0",
                 m, q1, r1, dz1, cyc);
      end
      take();
    end
  endtask

  task automatic test_annul();
    int cyc;
    @(negedge clk);
    dstart = 1'b1; annul = 1'b1; divisor = 32'd3; dividend = 32'd9;
    @(negedge clk);
    dstart = 1'b0; annul = 1'b0;
    n_tests++;
    if (rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL annul_idle: got rdy=%b, need 1", rdy1);
    end
    start(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    n_tests++;
    if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_calc: got rdy=%b vld=%b, need 1 0", rdy1, vld1);
    end
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (vld1) cyc++;
    end
    n_tests++;
    if (cyc != 0) begin
      n_fail++;
      $display("FAIL annul_novld: got %0d valid cycles, need 0", cyc);
    end
    start(1'b0, 32'hFFFFFFFF, 32'h10);
    wait_vld1(cyc);
    n_tests++;
    if ({q1, r1} !== {32'h0FFFFFFF, 32'hF}) begin
      n_fail++;
      $display("FAIL after_annul: got q=%h r=%h, need q=0fffffff r=f", q1, r1);
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    n_tests++;
    if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL annul_done: got rdy=%b vld=%b, need 1 0", rdy1, vld1);
    end
  endtask

  task automatic test_hold();
    int cyc, bad;
    start(1'b0, 32'd123456, 32'd1000);
    wait_vld1(cyc);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if ({vld1, q1, r1, dz1} !== {1'b1, 32'd123, 32'd456, 1'b0}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: got %0d unstable cycles (q=%0d r=%0d vld=%b), need 0 with q=123 r=456", bad, q1, r1, vld1);
    end
    take();
    n_tests++;
    if (rdy1 !== 1'b1 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got rdy=%b vld=%b, need 1 0", rdy1, vld1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start(1'b0, 32'd77, 32'd10);
    wait_vld1(cyc);
    @(negedge clk);
    res_rdy = 1'b1; dsigned = 1'b1; dividend = 32'hFFFFFFF7; divisor = 32'd3;
    @(negedge clk);
    res_rdy = 1'b0; dstart = 1'b1;
    @(negedge clk);
    dstart = 1'b0;
    n_tests++;
    if (rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got rdy=%b, need 0", rdy1);
    end
    wait_vld1(cyc);
    n_tests++;
    if ({q1, r1} !== {32'hFFFFFFFD, 32'd0}) begin
      n_fail++;
      $display("FAIL b2b_result: got q=%h r=%h, need q=fffffffd r=0", q1, r1);
    end
    take();
  endtask

  task automatic test_step2();
    int cyc;
    start(1'b0, 32'd100, 32'd7);
    cyc = 0;
    while (!vld2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if ({q2, r2, dz2} !== {32'd14, 32'd2, 1'b0} || cyc != 17) begin
      n_fail++;
      $display("FAIL s2_100_7: got q=%0d r=%0d dz=%b lat=%0d, need q=14 r=2 dz=0 lat=17", q2, r2, dz2, cyc);
    end
    res_rdy = 1'b1; annul = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0; annul = 1'b0;
    n_tests++;
    if (rdy2 !== 1'b1 || rdy1 !== 1'b1) begin
      n_fail++;
      $display("FAIL s2_idle: got rdy2=%b rdy1=%b, need 1 1", rdy2, rdy1);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    start(1'b0, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rdy1, vld1, q1, r1, dz1} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b vld=%b q=%h r=%h dz=%b, need 1 0 0 0 0", rdy1, vld1, q1, r1, dz1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start(1'b0, 32'd9, 32'd3);
    wait_vld1(cyc);
    n_tests++;
    if ({q1, r1, cyc} !== {32'd3, 32'd0, 33}) begin
      n_fail++;
      $display("FAIL post_reset_9_3: got q=%0d r=%0d lat=%0d, need q=3 r=0 lat=33", q1, r1, cyc);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_hold();
    test_back_to_back();
    test_step2();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/divn.md
DIVN -- requirements
Module: divn

Interface
REQ-001 Parameter N_WIDTH, default 32, operand and result width; SHALL be an even number >= 4.
REQ-002 Parameter STEP_BITS, default 1, quotient bits produced per iteration cycle; SHALL be 1 or 2, and N_WIDTH SHALL be a multiple of STEP_BITS.
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_divsigned  input  1  1 = two's-complement operation, 0 = unsigned; sampled at accept.
REQ-006 i_divstart  input  1  request; accepted when o_ready=1.
REQ-007 i_dividend  input  N_WIDTH  dividend; sampled at accept.
REQ-008 i_divisor  input  N_WIDTH  divisor; sampled at accept.
REQ-009 i_annul  input  1  cancels the operation in flight (pipeline flush).
REQ-010 i_res_rdy  input  1  consumer accepts the result.
REQ-011 o_ready  output  1  block idle and able to accept.
REQ-012 o_done_vld  output  1  result valid; held until taken.
REQ-013 o_quotient  output  N_WIDTH  sign-corrected quotient.
REQ-014 o_remainder  output  N_WIDTH  sign-corrected remainder.
REQ-015 o_div_zero  output  1  result was produced by divide-by-zero; valid with o_done_vld.

Function
REQ-016 States: IDLE, CALC, FIX, DONE; o_ready=1 only in IDLE; o_done_vld=1 only in DONE.
REQ-017 Accept = IDLE & i_divstart & !i_annul; i_divstart outside IDLE SHALL be ignored.
REQ-018 At accept with divisor!=0: latch operand magnitudes (negated when signed and MSB=1), both operand signs and the mode; load the iteration counter with N_WIDTH/STEP_BITS; go to CALC.
REQ-019 CALC: restoring division, STEP_BITS quotient bits per cycle, MSB first, with an N_WIDTH+1-bit trial subtraction per bit; after N_WIDTH/STEP_BITS cycles go to FIX.
REQ-020 FIX: one cycle; register o_quotient (negated if signed and operand signs differ) and o_remainder (negated if signed and the dividend was negative); go to DONE.
REQ-021 Latency: o_done_vld SHALL first be high N_WIDTH/STEP_BITS+1 cycles after the accept edge (33 for 32/1, 17 for 32/2).
REQ-022 Divide-by-zero at accept: go directly IDLE->DONE (1 cycle); o_quotient=all ones, o_remainder=i_dividend unmodified, o_div_zero=1, in both modes.
REQ-023 Signed overflow (MIN / -1): o_quotient=MIN, o_remainder=0, o_div_zero=0; no special state.
REQ-024 DONE: outputs SHALL stay stable while i_res_rdy=0; with i_res_rdy=1, return to IDLE on the next edge; the next accept is possible no earlier than the following cycle.
REQ-025 i_annul=1 in CALC, FIX or DONE: return to IDLE on the next edge, without asserting o_done_vld for that operation; a result already in DONE is discarded.
REQ-026 i_annul and i_divstart high together in IDLE: no accept.
REQ-027 o_quotient, o_remainder and o_div_zero are registered; their values outside DONE are don't-care, but they SHALL NOT change while in DONE.

Reset
REQ-028 Asynchronous assertion SHALL force IDLE, o_ready=1, o_done_vld=0, o_quotient=0, o_remainder=0, o_div_zero=0, counter=0, and all datapath registers to 0, including a reset mid-operation.
REQ-029 After deassertion, the first accept is possible in the first cycle.

Structure
REQ-030 Package div_pkg SHALL hold the state enum and the localparam for the iteration count (N_WIDTH/STEP_BITS).
REQ-031 Combinational sub-module div_step (one restoring bit: partial remainder plus divisor in; next partial remainder and quotient bit out) SHALL be instantiated STEP_BITS times in a chain.

Verification
REQ-032 Unsigned 100/7, N=32, S=1 -> q=14, r=2, o_div_zero=0, o_done_vld 33 cycles after accept.
REQ-033 Signed -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE; signed 100/-7 -> q=0xFFFFFFF2, r=2.
REQ-034 Divide by zero: 5/0 in both modes -> q=0xFFFFFFFF, r=5, o_div_zero=1, o_done_vld 1 cycle after accept; signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
REQ-035 Annul 10 cycles into CALC -> no o_done_vld, o_ready=1 the next cycle; a following unsigned 0xFFFFFFFF/0x10 -> q=0x0FFFFFFF, r=0xF.
REQ-036 Hold i_res_rdy=0 for 5 cycles in DONE -> outputs and o_done_vld stable; release -> IDLE next edge; with S=2, 100/7 -> q=14, r=2 with 17-cycle latency.
REQ-037 Assert reset 5 cycles into CALC -> all outputs at reset values immediately; a later 9/3 -> q=3, r=0.
